branch_resolution_unit: RTL
===========================

Name: branch_resolution_unit

Overview:
- Consumer-side counterpart of the 2-bit branch predictor.
- Records each prediction issued at fetch in an in-order queue, and checks it against the actual outcome when the branch resolves in EX.
- On a mismatch it produces the pipeline flush and the redirect PC.
- Every resolved branch is fed back to the predictor as a one-cycle branchex/outcome pulse; the unit also keeps saturating accuracy counters.

Parameters:
- DEPTH, 4, number of outstanding (fetched, unresolved) branches tracked; power of two, minimum 2.
- XLEN, 32, PC/target width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_br_valid  in  1  fetch issued a branch this cycle.
- if_pred  in  1  predictor output used for that branch (1 = taken).
- if_pc  in  XLEN  PC of that branch.
- fetch_stall  out  1  queue full; fetch must hold the branch.
- ex_br_valid  in  1  oldest outstanding branch resolves this cycle.
- ex_taken  in  1  actual outcome.
- ex_target  in  XLEN  computed taken target.
- flush  out  1  one-cycle pulse on misprediction.
- redirect_pc  out  XLEN  correct fetch PC; valid while flush = 1.
- branchex  out  1  update strobe to the predictor.
- outcome  out  1  resolved outcome to the predictor.
- br_count  out  CNT_W  resolved branches, saturating.
- mispred_count  out  CNT_W  mispredictions, saturating.
- underflow_err  out  1  sticky: resolve arrived with the queue empty.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - Outputs: flush, branchex, outcome, underflow_err = 0; redirect_pc = 0; both counters = 0.
  - Queue: empty, read/write pointers = 0, occupancy = 0.
- Queue:
  - FIFO of {pred, pc}, DEPTH entries.
  - Occupancy counter is log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- fetch_stall:
  - Combinational, equals (occupancy == DEPTH).
  - if_br_valid while full: the push is ignored; the source must hold its inputs until stall drops.
- Push: if_br_valid && !full writes the entry at the rising edge.
- Resolve (ex_br_valid in cycle N, queue non-empty):
  - Pop the head entry.
  - mispredict = (head.pred != ex_taken).
- Registered outputs in cycle N+1 (latency 1):
  - branchex = 1 and outcome = ex_taken, for exactly one cycle.
  - br_count increments, holding at all-ones.
  - If mispredict: flush = 1 for one cycle; mispred_count increments, saturating.
  - redirect_pc = ex_target if ex_taken, else head.pc + 4 (XLEN-bit, wraps modulo 2^XLEN).
  - redirect_pc holds its last value when no flush occurs.
- Misprediction squash:
  - At the same edge that registers flush, the whole queue is cleared (occupancy 0, pointers to 0). This squashes every younger branch.
  - A push in the same cycle as a mispredicting resolve is discarded.
- Push and non-mispredicting resolve in the same cycle:
  - Both take effect; occupancy is unchanged.
  - Allowed when full, because the pop frees a slot. fetch_stall still reads 1 that cycle (conservative); the source retries next cycle.
- Resolve on empty queue:
  - No pop, no counter change, branchex stays 0, flush stays 0.
  - underflow_err set; cleared only by reset.
- Back-to-back resolves on consecutive cycles are supported. After a flush the queue is empty, so a resolve in cycle N+1 is an underflow.
- Reset mid-operation: all state returns to reset values immediately; in-flight pulses are dropped.

Decomposition:
- Shared package bru_pkg:
  - XLEN default.
  - Queue entry typedef {logic pred; logic [XLEN-1:0] pc}.
  - Constant PC_INC = 4.
- One natural sub-module: bru_pred_fifo.
  - Parameterised DEPTH, WIDTH.
  - Ports: push, pop, clear, full, empty, head data.
  - Asynchronous active-low reset.
- Compare/redirect logic and the counters stay in the top level.

Test Plan:
- Correct predict: push {pred=1, pc=0x100}; resolve ex_taken=1, ex_target=0x200 -> next cycle branchex=1, outcome=1, flush=0, br_count=1, mispred_count=0, queue empty.
- Mispredict not-taken: push {pred=1, pc=0x100}; resolve ex_taken=0 -> next cycle flush=1, redirect_pc=0x104, outcome=0, mispred_count=1.
- Mispredict taken with younger branches: push 3 entries, first with pred=0; resolve ex_taken=1, ex_target=0x40 -> flush=1, redirect_pc=0x40, queue empty; the next resolve sets underflow_err=1.
- Full/stall: push 4 entries -> fetch_stall=1 and a fifth push is ignored. Same-cycle push+pop (pops correct) -> occupancy stays 4, FIFO order preserved.
- Counter saturation: CNT_W=4, 20 correct resolves -> br_count=15, held.
- Async reset mid-flush: drop rst_n in the cycle flush=1 -> flush, counters, occupancy and underflow_err all 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit and its prediction queue.
package bru_pkg;

  localparam int BRU_XLEN = 32;
  localparam int unsigned PC_INC = 4;

  typedef struct packed {
    logic                pred;
    logic [BRU_XLEN-1:0] pc;
  } bru_entry_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order queue of outstanding fetched branches; clear squashes every entry at once.
module bru_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rptr];

  // Control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Checks queued fetch predictions against EX outcomes, issues flush/redirect and predictor updates.
module branch_resolution_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = BRU_XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_br_valid,
  input  logic             if_pred,
  input  logic [XLEN-1:0]  if_pc,
  output logic             fetch_stall,
  input  logic             ex_br_valid,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             branchex,
  output logic             outcome,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count,
  output logic             underflow_err
);

  localparam int EW = XLEN + 1;

  logic [EW-1:0]   head_data;
  logic            head_pred;
  logic [XLEN-1:0] head_pc;
  logic            full;
  logic            empty;
  logic            pop_ok;
  logic            mispred;
  logic            push_ok;
  logic [XLEN-1:0] redirect_nxt;

  logic             vld_p1;
  logic             outcome_p1;
  logic             flush_p1;
  logic [XLEN-1:0]  redirect_p1;
  logic [CNT_W-1:0] br_cnt_p1;
  logic [CNT_W-1:0] mis_cnt_p1;
  logic             uflow_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign {head_pred, head_pc} = head_data;

  // A pop frees a slot, so a push is accepted even when full; a mispredict squashes it.
  assign pop_ok       = ex_br_valid && !empty;
  assign mispred      = pop_ok && (head_pred != ex_taken);
  assign push_ok      = if_br_valid && (!full || pop_ok) && !mispred;
  assign redirect_nxt = ex_taken ? ex_target : head_pc + XLEN'(PC_INC);
  assign fetch_stall  = full;

  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop_ok),
    .clear (mispred),
    .din   ({if_pred, if_pc}),
    .full  (full),
    .empty (empty),
    .head  (head_data)
  );

  // Stage p0 -> p1: resolve results registered one cycle after EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      outcome_p1  <= 1'b0;
      flush_p1    <= 1'b0;
      redirect_p1 <= '0;
      br_cnt_p1   <= '0;
      mis_cnt_p1  <= '0;
      uflow_p1    <= 1'b0;
    end else begin
      vld_p1     <= pop_ok;
      outcome_p1 <= pop_ok && ex_taken;
      flush_p1   <= mispred;
      if (mispred) begin
        redirect_p1 <= redirect_nxt;
        mis_cnt_p1  <= sat_inc(mis_cnt_p1);
      end
      if (pop_ok) br_cnt_p1 <= sat_inc(br_cnt_p1);
      if (ex_br_valid && empty) uflow_p1 <= 1'b1;
    end
  end

  assign branchex      = vld_p1;
  assign outcome       = outcome_p1;
  assign flush         = flush_p1;
  assign redirect_pc   = redirect_p1;
  assign br_count      = br_cnt_p1;
  assign mispred_count = mis_cnt_p1;
  assign underflow_err = uflow_p1;

endmodule
